mux_logic_pipe: RTL and testbench

- Parametrised, pipelined bitwise logic unit that generalises the 2:1-mux gate set (AND, OR, NOT, XOR, XNOR, NAND, NOR) to WIDTH-bit operands with a runtime opcode.
- Every gate is realised from 2:1 mux cells only.
- Adds a valid/ready handshake with backpressure, a chain mode that feeds back the previous result, status flags and a transaction counter.
- Sits between an operand source and a result consumer in the gate-level datapath experiments.

---
 rtl/mux_logic_pkg.sv | 17 +
 rtl/mux2_cell.sv | 12 +
 rtl/mux_logic_pipe.sv | 132 +++++++++++++
 tb/tb_mux_logic_pipe.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_logic_pkg.sv
// rtl/mux_logic_pkg.sv - opcodes and default sizes for the mux-built logic pipe
// Contents: OP_* opcode encodings (3 bits), DEF_WIDTH, DEF_CNT_W.
package mux_logic_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_XNOR = 3'd4;
    localparam logic [2:0] OP_NAND = 3'd5;
    localparam logic [2:0] OP_NOR  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/mux2_cell.sv
// rtl/mux2_cell.sv - 1-bit combinational 2:1 mux, the only gate primitive of the datapath
// Ports: d0 (selected when sel=0), d1 (selected when sel=1), sel, y.
module mux2_cell (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_logic_pipe.sv
// rtl/mux_logic_pipe.sv - two-stage valid/ready bitwise logic unit built from mux2 cells
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready        operand handshake; in_a, in_b, in_op, in_chain
//   out_valid/out_ready      result handshake; out_res, out_zero, out_ones
//   out_count                results consumed, modulo 2^CNT_W
module mux_logic_pipe
    import mux_logic_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_zero,
    output logic             out_ones,
    output logic [CNT_W-1:0] out_count
);

    logic             s1_v;
    logic             s1_chain;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;

    logic             s2_v;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] last_res;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] res_d;

    logic s1_adv;
    logic ready_int;
    logic in_xfer;
    logic s2_load;
    logic out_xfer;

    assign s1_adv    = !s2_v || out_ready;
    assign ready_int = !s1_v || s1_adv;
    // Flops are held by the async reset anyway; only the visible ready is
    // masked so the source never sees a handshake while reset is asserted.
    assign in_ready  = ready_int && !rst;
    assign in_xfer   = in_valid && ready_int;
    assign s2_load   = s1_adv && s1_v;
    assign out_xfer  = s2_v && out_ready;

    // Per-bit datapath. Opcode tree leaf order follows OP_AND..OP_PASS:
    // op[0] picks within pairs, op[1] between pairs, op[2] between halves.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic na, nb;
        logic g_and, g_or, g_xor, g_xnor, g_nand, g_nor;
        logic t01, t23, t45, t67, t03, t47;

        // Chain mode swaps B for the previous result.
        mux2_cell u_bsel (.d0(s1_b[i]), .d1(last_res[i]), .sel(s1_chain), .y(b_eff[i]));

        mux2_cell u_na   (.d0(1'b1),     .d1(1'b0),     .sel(s1_a[i]), .y(na));
        mux2_cell u_nb   (.d0(1'b1),     .d1(1'b0),     .sel(b_eff[i]), .y(nb));
        mux2_cell u_and  (.d0(1'b0),     .d1(b_eff[i]), .sel(s1_a[i]), .y(g_and));
        mux2_cell u_or   (.d0(b_eff[i]), .d1(1'b1),     .sel(s1_a[i]), .y(g_or));
        mux2_cell u_xor  (.d0(b_eff[i]), .d1(nb),       .sel(s1_a[i]), .y(g_xor));
        mux2_cell u_xnor (.d0(nb),       .d1(b_eff[i]), .sel(s1_a[i]), .y(g_xnor));
        mux2_cell u_nand (.d0(1'b1),     .d1(nb),       .sel(s1_a[i]), .y(g_nand));
        mux2_cell u_nor  (.d0(nb),       .d1(1'b0),     .sel(s1_a[i]), .y(g_nor));

        mux2_cell u_t01 (.d0(g_and),  .d1(g_or),    .sel(s1_op[0]), .y(t01));
        mux2_cell u_t23 (.d0(na),     .d1(g_xor),   .sel(s1_op[0]), .y(t23));
        mux2_cell u_t45 (.d0(g_xnor), .d1(g_nand),  .sel(s1_op[0]), .y(t45));
        mux2_cell u_t67 (.d0(g_nor),  .d1(s1_a[i]), .sel(s1_op[0]), .y(t67));
        mux2_cell u_t03 (.d0(t01),    .d1(t23),     .sel(s1_op[1]), .y(t03));
        mux2_cell u_t47 (.d0(t45),    .d1(t67),     .sel(s1_op[1]), .y(t47));
        mux2_cell u_top (.d0(t03),    .d1(t47),     .sel(s1_op[2]), .y(res_d[i]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v     <= 1'b0;
            s1_chain <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
            s2_v     <= 1'b0;
            res_q    <= '0;
            last_res <= '0;
            cnt_q    <= '0;
        end else begin
            if (in_xfer) begin
                s1_v     <= 1'b1;
                s1_a     <= in_a;
                s1_b     <= in_b;
                s1_op    <= in_op;
                s1_chain <= in_chain;
            end else if (s1_adv) begin
                s1_v <= 1'b0;
            end

            // last_res updates on the same edge the result is registered, so a
            // chained word directly behind its predecessor sees it with no bubble.
            if (s2_load) begin
                s2_v     <= 1'b1;
                res_q    <= res_d;
                last_res <= res_d;
            end else if (out_ready) begin
                s2_v <= 1'b0;
            end

            if (out_xfer) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign out_valid = s2_v;
    assign out_res   = res_q;
    assign out_count = cnt_q;
    // Flags describe the held result and read low while nothing is valid,
    // so the idle/reset state shows every output at 0.
    assign out_zero  = s2_v && (res_q == '0);
    assign out_ones  = s2_v && (&res_q);

endmodule

// File: tb/tb_mux_logic_pipe.sv
// tb/tb_mux_logic_pipe.sv - directed self-checking bench for mux_logic_pipe
module tb_mux_logic_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_op;
    logic       in_chain;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_res;
    logic       out_zero;
    logic       out_ones;
    logic [1:0] out_count;

    int n_cmp;
    int n_err;

    logic [7:0] gate_exp [8];
    logic [1:0] cnt_exp  [6];

    mux_logic_pipe #(.WIDTH(8), .CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_chain  (in_chain),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_zero  (out_zero),
        .out_ones  (out_ones),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic ch);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_chain = ch;
    endtask

    // One word accepted, checked one edge later, then consumed.
    task automatic send_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input logic [2:0] op, input logic ch, input logic [7:0] exp);
        drive(1'b1, a, b, op, ch);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        tick();
        expect_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        expect_eq(tag, 32'(out_res), 32'(exp));
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        gate_exp = '{8'h88, 8'hEE, 8'h33, 8'h66, 8'h99, 8'h77, 8'h11, 8'hCC};
        cnt_exp  = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        tick();
        tick();
        expect_eq("rst_out_valid", 32'(out_valid), 32'd0);
        expect_eq("rst_in_ready",  32'(in_ready),  32'd0);
        expect_eq("rst_out_res",   32'(out_res),   32'd0);
        expect_eq("rst_out_zero",  32'(out_zero),  32'd0);
        expect_eq("rst_out_ones",  32'(out_ones),  32'd0);
        expect_eq("rst_out_count", 32'(out_count), 32'd0);
        rst = 1'b0;
        #1;
        expect_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

        // All eight opcodes on a=CC, b=AA.
        for (int op = 0; op < 8; op++) begin
            send_check($sformatf("gate_op%0d", op), 8'hCC, 8'hAA, 3'(op), 1'b0, gate_exp[op]);
        end

        // Flags.
        drive(1'b1, 8'h5A, 8'h5A, 3'd3, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        tick();
        expect_eq("flag_xor_res",  32'(out_res),  32'h00);
        expect_eq("flag_xor_zero", 32'(out_zero), 32'd1);
        expect_eq("flag_xor_ones", 32'(out_ones), 32'd0);
        tick();
        drive(1'b1, 8'h00, 8'h00, 3'd6, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        tick();
        expect_eq("flag_nor_res",  32'(out_res),  32'hFF);
        expect_eq("flag_nor_ones", 32'(out_ones), 32'd1);
        expect_eq("flag_nor_zero", 32'(out_zero), 32'd0);
        tick();

        // Chain: 0F|F0 = FF, then 3C ^ FF = C3 back-to-back.
        drive(1'b1, 8'h0F, 8'hF0, 3'd1, 1'b0);
        #1;
        expect_eq("chain_rdy0", 32'(in_ready), 32'd1);
        tick();
        drive(1'b1, 8'h3C, 8'h55, 3'd3, 1'b1);
        #1;
        expect_eq("chain_rdy1", 32'(in_ready), 32'd1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        expect_eq("chain_res0", 32'(out_res), 32'hFF);
        tick();
        expect_eq("chain_res1", 32'(out_res), 32'hC3);
        expect_eq("chain_v1",   32'(out_valid), 32'd1);
        tick();

        // Backpressure: out_ready low for 5 cycles with words always offered.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 0)      drive(1'b1, 8'h12, 8'h34, 3'd0, 1'b0);
            else if (k == 1) drive(1'b1, 8'hF0, 8'h0F, 3'd3, 1'b0);
            else             drive(1'b1, 8'hAA, 8'h00, 3'd7, 1'b0);
            #1;
            expect_eq($sformatf("bp_rdy%0d", k), 32'(in_ready), (k < 2) ? 32'd1 : 32'd0);
            if (k >= 2) begin
                expect_eq($sformatf("bp_hold%0d", k), 32'(out_res), 32'h10);
                expect_eq($sformatf("bp_v%0d", k), 32'(out_valid), 32'd1);
            end
            tick();
        end
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        out_ready = 1'b1;
        #1;
        expect_eq("bp_drain0", 32'(out_res), 32'h10);
        tick();
        expect_eq("bp_drain1", 32'(out_res), 32'hFF);
        expect_eq("bp_drain1_v", 32'(out_valid), 32'd1);
        tick();
        expect_eq("bp_empty", 32'(out_valid), 32'd0);

        // Reset while both stages hold words; 14 transfers so far -> count 2.
        out_ready = 1'b0;
        drive(1'b1, 8'h0F, 8'h30, 3'd1, 1'b0);
        tick();
        drive(1'b1, 8'h11, 8'h22, 3'd0, 1'b0);
        tick();
        expect_eq("pre_rst_valid", 32'(out_valid), 32'd1);
        expect_eq("pre_rst_count", 32'(out_count), 32'd2);
        rst = 1'b1;
        #1;
        expect_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        expect_eq("mid_rst_rdy",   32'(in_ready),  32'd0);
        expect_eq("mid_rst_count", 32'(out_count), 32'd0);
        expect_eq("mid_rst_res",   32'(out_res),   32'd0);
        tick();
        tick();
        expect_eq("mid_rst_valid2", 32'(out_valid), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        #1;
        expect_eq("rel_rdy", 32'(in_ready), 32'd1);

        // First chained op after reset sees B=0: 5A | 00.
        send_check("rst_chain", 8'h5A, 8'hFF, 3'd1, 1'b1, 8'h5A);
        expect_eq("rst_chain_cnt", 32'(out_count), 32'd1);

        // Streaming PASS words at full rate; count continues 2, 3, 0, 1.
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(1'b1, 8'(8'h81 + i), 8'h00, 3'd7, 1'b0);
            else       drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
            #1;
            if (i < 4) expect_eq($sformatf("str_rdy%0d", i), 32'(in_ready), 32'd1);
            tick();
            if (i >= 1 && i <= 4) begin
                expect_eq($sformatf("str_res%0d", i), 32'(out_res), 32'(8'h81 + i - 1));
                expect_eq($sformatf("str_v%0d", i), 32'(out_valid), 32'd1);
            end
            expect_eq($sformatf("str_cnt%0d", i), 32'(out_count), 32'(cnt_exp[i]));
        end
        expect_eq("str_end_v", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
